// File: rtl/parity_stream_arbiter.sv
// Packet-level weighted round-robin merge of the even/odd parity classes into a
// single registered AXI-Stream, with tuser marking the source class of each beat.
module parity_stream_arbiter #(
  parameter int DATA_W      = 8,
  parameter int EVEN_WEIGHT = 1,
  parameter int ODD_WEIGHT  = 1,
  parameter int CNT_W       = 16
) (
  input  logic              a_clk,
  input  logic              axis_aresetn,
  input  logic              axis_s_tvalid_even,
  output logic              axis_s_tready_even,
  input  logic [DATA_W-1:0] axis_s_tdata_even,
  input  logic              axis_s_tlast_even,
  input  logic              axis_s_tvalid_odd,
  output logic              axis_s_tready_odd,
  input  logic [DATA_W-1:0] axis_s_tdata_odd,
  input  logic              axis_s_tlast_odd,
  output logic              axis_m_tvalid,
  input  logic              axis_m_tready,
  output logic [DATA_W-1:0] axis_m_tdata,
  output logic              axis_m_tlast,
  output logic              axis_m_tuser,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_cnt_even,
  output logic [CNT_W-1:0]  pkt_cnt_odd
);

  typedef enum logic [1:0] {IDLE, GRANT_EVEN, GRANT_ODD} state_t;

  localparam logic [3:0]       EVEN_W  = 4'(EVEN_WEIGHT);
  localparam logic [3:0]       ODD_W   = 4'(ODD_WEIGHT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             state_q, state_d;
  logic               pref_odd_q, pref_odd_d;
  logic [3:0]         wcnt_q, wcnt_d;
  logic               m_valid_q, m_valid_d;
  logic [DATA_W-1:0]  m_data_q, m_data_d;
  logic               m_last_q, m_last_d;
  logic               m_user_q, m_user_d;
  logic [CNT_W-1:0]   cnt_even_q, cnt_even_d;
  logic [CNT_W-1:0]   cnt_odd_q, cnt_odd_d;

  logic               slot_free, grant_odd, accept, acc_last, drain;
  logic [DATA_W-1:0]  acc_data;
  logic [3:0]         grant_weight, wcnt_inc;

  // The slice can take a beat when empty or when it is being drained this cycle.
  assign slot_free          = !m_valid_q || axis_m_tready;
  assign grant_odd          = (state_q == GRANT_ODD);
  assign axis_s_tready_even = axis_aresetn && (state_q == GRANT_EVEN) && slot_free;
  assign axis_s_tready_odd  = axis_aresetn && grant_odd && slot_free;

  assign accept   = grant_odd ? (axis_s_tvalid_odd && axis_s_tready_odd)
                              : (axis_s_tvalid_even && axis_s_tready_even);
  assign acc_data = grant_odd ? axis_s_tdata_odd : axis_s_tdata_even;
  assign acc_last = grant_odd ? axis_s_tlast_odd : axis_s_tlast_even;
  assign drain    = m_valid_q && axis_m_tready;

  assign grant_weight = grant_odd ? ODD_W : EVEN_W;
  assign wcnt_inc     = wcnt_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    pref_odd_d = pref_odd_q;
    wcnt_d     = wcnt_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_last_d   = m_last_q;
    m_user_d   = m_user_q;
    cnt_even_d = cnt_even_q;
    cnt_odd_d  = cnt_odd_q;

    case (state_q)
      IDLE: begin
        if (axis_s_tvalid_even && axis_s_tvalid_odd)
          state_d = pref_odd_q ? GRANT_ODD : GRANT_EVEN;
        else if (axis_s_tvalid_even)
          state_d = GRANT_EVEN;
        else if (axis_s_tvalid_odd)
          state_d = GRANT_ODD;
      end
      GRANT_EVEN, GRANT_ODD: begin
        // A finished packet from the non-preferred class restarts the weight run.
        if (accept && acc_last) begin
          state_d = IDLE;
          if (grant_odd == pref_odd_q) begin
            if (wcnt_inc == grant_weight) begin
              pref_odd_d = !pref_odd_q;
              wcnt_d     = 4'd0;
            end else begin
              wcnt_d = wcnt_inc;
            end
          end else begin
            wcnt_d = 4'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = acc_data;
      m_last_d  = acc_last;
      m_user_d  = grant_odd;
    end else if (drain) begin
      m_valid_d = 1'b0;
    end

    if (drain && m_last_q) begin
      if (m_user_q) cnt_odd_d  = cnt_odd_q + CNT_ONE;
      else          cnt_even_d = cnt_even_q + CNT_ONE;
    end
  end

  always_ff @(posedge a_clk) begin
    if (!axis_aresetn) begin
      state_q    <= IDLE;
      pref_odd_q <= 1'b0;
      wcnt_q     <= 4'd0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
      m_user_q   <= 1'b0;
      cnt_even_q <= '0;
      cnt_odd_q  <= '0;
    end else begin
      state_q    <= state_d;
      pref_odd_q <= pref_odd_d;
      wcnt_q     <= wcnt_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_last_q   <= m_last_d;
      m_user_q   <= m_user_d;
      cnt_even_q <= cnt_even_d;
      cnt_odd_q  <= cnt_odd_d;
    end
  end

  assign axis_m_tvalid = m_valid_q;
  assign axis_m_tdata  = m_data_q;
  assign axis_m_tlast  = m_last_q;
  assign axis_m_tuser  = m_user_q;
  assign busy          = (state_q != IDLE);
  assign pkt_cnt_even  = cnt_even_q;
  assign pkt_cnt_odd   = cnt_odd_q;

endmodule

// File: doc/parity_stream_arbiter.md
Name: parity_stream_arbiter

Overview:
- Merges the two classified AXI-Stream outputs of the parity filter (even class, odd class) into one downstream 8-bit AXI-Stream.
- Arbitration is packet-level and weighted round-robin; a grant holds until the granted input's tlast beat is accepted.
- Output is fully registered, with a 1-entry register slice. Each beat carries a tuser bit identifying its source class.
- Per-class packet counters expose traffic statistics to the control plane.

Parameters:
DATA_W, 8, tdata width of all stream interfaces
EVEN_WEIGHT, 1, consecutive packets granted to even before rotating (1..15)
ODD_WEIGHT, 1, consecutive packets granted to odd before rotating (1..15)
CNT_W, 16, width of packet statistics counters

Ports:
a_clk  in  1  single clock, all logic on rising edge
axis_aresetn  in  1  reset, synchronous, active-low
axis_s_tvalid_even  in  1  even-class input valid
axis_s_tready_even  out  1  even-class input ready
axis_s_tdata_even  in  DATA_W  even-class data
axis_s_tlast_even  in  1  even-class end of packet
axis_s_tvalid_odd  in  1  odd-class input valid
axis_s_tready_odd  out  1  odd-class input ready
axis_s_tdata_odd  in  DATA_W  odd-class data
axis_s_tlast_odd  in  1  odd-class end of packet
axis_m_tvalid  out  1  merged output valid
axis_m_tready  in  1  downstream ready
axis_m_tdata  out  DATA_W  merged data
axis_m_tlast  out  1  merged end of packet
axis_m_tuser  out  1  source class of beat: 0 even, 1 odd
busy  out  1  high while a grant is held (state != IDLE)
pkt_cnt_even  out  CNT_W  even packets forwarded (tlast accepted at output)
pkt_cnt_odd  out  CNT_W  odd packets forwarded

Behaviour:
- Reset: axis_aresetn sampled low at an a_clk edge sets the following on that edge:
  - state=IDLE, preferred class=even, weight counter=0.
  - axis_m_tvalid/tdata/tlast/tuser=0, both pkt counters=0, busy=0.
  - Both tready outputs=0 while reset is low.
- Reset mid-packet: the in-flight packet is abandoned and the output slice is cleared. No partial-packet recovery.
- State machine: IDLE, GRANT_EVEN, GRANT_ODD.
- IDLE:
  - If only one input has tvalid=1, go to that input's GRANT state.
  - If both inputs have tvalid=1, go to the preferred class's GRANT state.
  - If neither is valid, stay in IDLE.
  - The IDLE->GRANT decision takes 1 cycle. No beat is accepted in the IDLE cycle.
- GRANT_x input handshake:
  - axis_s_tready_x = (!axis_m_tvalid || axis_m_tready).
  - The other input's tready = 0.
- GRANT_x beat acceptance: on the granted input's tvalid && tready, the beat loads into the output slice with tuser = class.
- GRANT_x exit: when the accepted input beat has tlast=1, the weight counter increments and the state returns to IDLE on the same edge.
- Weight rotation:
  - When weight counter reaches x's WEIGHT, the preferred class flips and the counter resets to 0.
  - A grant to the non-preferred class (it was the only one valid) resets the counter to 0 and does not flip preference.
- Output slice:
  - axis_m_tvalid is set on load.
  - It clears when axis_m_tready=1 and no new load occurs in the same cycle.
  - Simultaneous drain+load keeps tvalid=1 with the new beat.
  - tdata/tlast/tuser are stable while tvalid=1 && tready=0 (AXI rule).
- Latency: input acceptance to axis_m_tvalid = 1 cycle. The first beat after idle has 2 cycles from input tvalid.
- Throughput: 1 beat/cycle within a packet. There is one idle cycle between packets, for IDLE re-arbitration.
- Counters:
  - pkt_cnt_x increments when axis_m_tvalid && axis_m_tready && axis_m_tlast && tuser==x.
  - Counters wrap modulo 2^CNT_W with no saturation.
- Input tvalid deasserting mid-packet: the grant is held and no switch occurs (the packet lock is absolute).
- busy = (state != IDLE).

Test Plan:
- Reset then idle: aresetn low 2 cycles, no valids → both tready=0, m_tvalid=0, counters 0, busy=0 throughout.
- Single even packet: 3 beats 0x03,0x05,0x06 (last on 0x06), m_tready=1 → output 0x03,0x05,0x06, tuser=0, tlast on third beat only; first output 2 cycles after s_tvalid; pkt_cnt_even=1.
- Both classes contend, weights 1/1: even and odd each offer 2 two-beat packets continuously → output packet order E,O,E,O, no interleaving within a packet; pkt_cnt_even=2, pkt_cnt_odd=2.
- Weights EVEN_WEIGHT=2, ODD_WEIGHT=1 with both saturating → packet order E,E,O,E,E,O.
- Backpressure: m_tready low for 4 cycles mid-packet (odd packet 0x01,0x02,0x07) → m_tdata holds 0x02 steady, s_tready_odd=0 while slice full, no beat lost or duplicated.
- Reset mid-packet plus counter wrap:
  - Assert aresetn low after beat 2 of a 4-beat packet → outputs clear next edge; a new packet forwards cleanly afterward.
  - With CNT_W=2, 5 odd packets → pkt_cnt_odd=1.
